// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and match helper for the hazard/forward unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A source register hits a slot only when it is really read, is not x0 and the slot writes it.
  function automatic logic reg_hit(input logic       used,
                                   input logic [4:0] rs,
                                   input logic       wr,
                                   input logic [4:0] rd);
    return used && (rs != REG_X0) && wr && (rd == rs);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that holds at its maximum value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-side hazard control: registered EX forward selects,
// load-use stall and branch-redirect flushes, driven from a shadow EX/MEM scoreboard.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       ID_rd_addr,
  input  logic             ID_rd_wren,
  input  logic             ID_mem_rden,
  input  logic             ID_insn_vld,
  input  logic             MEM_br_sel,
  output logic [1:0]       ID_forward_A,
  output logic [1:0]       ID_forward_B,
  output logic             IF_stall,
  output logic             ID_stall,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             MEM_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [4:0] r_ex_rd;
  logic       r_ex_wr;
  logic       r_ex_ld;
  logic [4:0] r_mem_rd;
  logic       r_mem_wr;
  fwd_sel_e   r_fwd_a;
  fwd_sel_e   r_fwd_b;

  logic       w_redirect;
  logic       w_hit_ex_a;
  logic       w_hit_ex_b;
  logic       w_hit_mem_a;
  logic       w_hit_mem_b;
  logic       w_stall;
  logic       w_ex_bubble;
  fwd_sel_e   w_fwd_a_nxt;
  fwd_sel_e   w_fwd_b_nxt;

  // Flush outputs must read 0 while reset is held, even if the branch input is high.
  assign w_redirect = MEM_br_sel & ~i_rst;

  assign w_hit_ex_a  = reg_hit(ID_rs1_used, ID_rs1_addr, r_ex_wr,  r_ex_rd);
  assign w_hit_ex_b  = reg_hit(ID_rs2_used, ID_rs2_addr, r_ex_wr,  r_ex_rd);
  assign w_hit_mem_a = reg_hit(ID_rs1_used, ID_rs1_addr, r_mem_wr, r_mem_rd);
  assign w_hit_mem_b = reg_hit(ID_rs2_used, ID_rs2_addr, r_mem_wr, r_mem_rd);

  assign w_stall     = ID_insn_vld & r_ex_ld & (w_hit_ex_a | w_hit_ex_b) & ~w_redirect;
  assign w_ex_bubble = EX_flush | ~ID_insn_vld;

  assign IF_stall  = w_stall;
  assign ID_stall  = w_stall;
  assign ID_flush  = w_redirect;
  assign EX_flush  = w_stall | w_redirect;
  assign MEM_flush = w_redirect;

  // A load still in EX has no data yet, so it can never be a forward source from MEM_alu_data.
  always_comb begin
    w_fwd_a_nxt = FWD_RF;
    w_fwd_b_nxt = FWD_RF;
    if (!w_ex_bubble) begin
      if (w_hit_ex_a && !r_ex_ld) begin
        w_fwd_a_nxt = FWD_MEM;
      end else if (w_hit_mem_a) begin
        w_fwd_a_nxt = FWD_WB;
      end
      if (w_hit_ex_b && !r_ex_ld) begin
        w_fwd_b_nxt = FWD_MEM;
      end else if (w_hit_mem_b) begin
        w_fwd_b_nxt = FWD_WB;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex_rd  <= REG_X0;
      r_ex_wr  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_rd <= REG_X0;
      r_mem_wr <= 1'b0;
      r_fwd_a  <= FWD_RF;
      r_fwd_b  <= FWD_RF;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_wr <= r_ex_wr & ~MEM_flush;
      r_ex_rd  <= ID_rd_addr;
      r_ex_wr  <= ID_rd_wren  & ~w_ex_bubble;
      r_ex_ld  <= ID_mem_rden & ~w_ex_bubble;
      r_fwd_a  <= w_fwd_a_nxt;
      r_fwd_b  <= w_fwd_b_nxt;
    end
  end

  assign ID_forward_A = r_fwd_a;
  assign ID_forward_B = r_fwd_b;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_stall),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_redirect),
    .o_cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit (16-bit and 2-bit counter builds)
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] r1, r2, rd;
  logic       u1, u2, wr, ld, vld, br;

  logic [1:0]  fa, fb, fa2, fb2;
  logic        ifs, ids, idf, exf, memf, ifs2, ids2, idf2, exf2, memf2;
  logic [15:0] scnt, fcnt;
  logic [1:0]  scnt2, fcnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .ID_rs1_addr(r1), .ID_rs2_addr(r2), .ID_rs1_used(u1), .ID_rs2_used(u2),
    .ID_rd_addr(rd), .ID_rd_wren(wr), .ID_mem_rden(ld), .ID_insn_vld(vld), .MEM_br_sel(br),
    .ID_forward_A(fa), .ID_forward_B(fb), .IF_stall(ifs), .ID_stall(ids),
    .ID_flush(idf), .EX_flush(exf), .MEM_flush(memf),
    .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  hazard_forward_unit #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .ID_rs1_addr(r1), .ID_rs2_addr(r2), .ID_rs1_used(u1), .ID_rs2_used(u2),
    .ID_rd_addr(rd), .ID_rd_wren(wr), .ID_mem_rden(ld), .ID_insn_vld(vld), .MEM_br_sel(br),
    .ID_forward_A(fa2), .ID_forward_B(fb2), .IF_stall(ifs2), .ID_stall(ids2),
    .ID_flush(idf2), .EX_flush(exf2), .MEM_flush(memf2),
    .o_stall_cnt(scnt2), .o_flush_cnt(fcnt2)
  );

  // Reference: the instruction records sitting one and two stages ahead of ID.
  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         ld;
  } slot_t;

  slot_t m_ex, m_mem;
  logic [1:0] e_fa, e_fb;
  int e_scnt, e_fcnt, e_scnt2, e_fcnt2;

  function automatic bit hit(slot_t s, bit used, logic [4:0] rs);
    return used && (rs != 5'd0) && s.wr && (s.rd == rs);
  endfunction

  function automatic bit m_stall();
    return vld && m_ex.ld && (hit(m_ex, u1, r1) || hit(m_ex, u2, r2)) && !br;
  endfunction

  function automatic logic [4:0] m_ctrl();
    bit s;
    s = m_stall();
    return {s, s, br, s | br, br};
  endfunction

  function automatic logic [1:0] m_sel(bit used, logic [4:0] rs, bit bubble);
    if (bubble) return 2'b00;
    if (hit(m_ex, used, rs) && !m_ex.ld) return 2'b10;
    if (hit(m_mem, used, rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic drive(bit v, bit a_u, logic [4:0] a, bit b_u, logic [4:0] b,
                       bit w, logic [4:0] d, bit l, bit bs);
    vld = v; u1 = a_u; r1 = a; u2 = b_u; r2 = b; wr = w; rd = d; ld = l; br = bs;
    #1;
  endtask

  task automatic tick();
    bit st, bub;
    logic [1:0] na, nb;
    st  = m_stall();
    bub = st || br || !vld;
    na  = m_sel(u1, r1, bub);
    nb  = m_sel(u2, r2, bub);
    @(posedge clk);
    if (br) m_mem = '{m_ex.rd, 1'b0, 1'b0};
    else    m_mem = m_ex;
    if (bub) m_ex = '{rd, 1'b0, 1'b0};
    else     m_ex = '{rd, wr, ld};
    e_fa = na;
    e_fb = nb;
    if (st) begin
      e_scnt  = sat(e_scnt, 65535);
      e_scnt2 = sat(e_scnt2, 3);
    end
    if (br) begin
      e_fcnt  = sat(e_fcnt, 65535);
      e_fcnt2 = sat(e_fcnt2, 3);
    end
    #1;
  endtask

  task automatic model_clear();
    m_ex = '{5'd0, 1'b0, 1'b0};
    m_mem = '{5'd0, 1'b0, 1'b0};
    e_fa = 2'b00; e_fb = 2'b00;
    e_scnt = 0; e_fcnt = 0; e_scnt2 = 0; e_fcnt2 = 0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fa, fb, ifs, ids, idf, exf, memf, scnt, fcnt, fa2, fb2, ifs2, ids2, idf2, exf2, memf2, scnt2, fcnt2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got fa=%b fb=%b ctrl=%b scnt=%0d fcnt=%0d exp all zero",
               fa, fb, {ifs, ids, idf, exf, memf}, scnt, fcnt);
    end
  endtask

  // add x5,x1,x2 ; sub x6,x5,x3
  task automatic test_ex_forward();
    do_reset();
    drive(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 0); tick();
    drive(1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 0, 0);
    checks++;
    if (ifs !== 1'b0) begin failures++; $display("FAIL ex_fwd_nostall got=%b exp=0", ifs); end
    tick();
    checks++;
    if ({fa, fb} !== 4'b1000) begin failures++; $display("FAIL ex_fwd_sel got A=%b B=%b exp A=10 B=00", fa, fb); end
  endtask

  // add x5 ; nop ; or x7,x4,x5
  task automatic test_mem_forward();
    do_reset();
    drive(1, 1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 0); tick();
    drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0); tick();
    drive(1, 1, 5'd4, 1, 5'd5, 1, 5'd7, 0, 0); tick();
    checks++;
    if ({fa, fb} !== 4'b0001) begin failures++; $display("FAIL mem_fwd_sel got A=%b B=%b exp A=00 B=01", fa, fb); end
  endtask

  // lw x5,0(x1) ; add x6,x5,x5
  task automatic test_load_use();
    do_reset();
    drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0); tick();
    drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0);
    checks++;
    if ({ifs, ids, idf, exf, memf} !== 5'b11010) begin
      failures++; $display("FAIL load_use_stall got=%b exp=11010", {ifs, ids, idf, exf, memf});
    end
    tick();
    checks++;
    if ({ifs, ids, exf, fa, fb} !== 7'b0000000) begin
      failures++; $display("FAIL load_use_one_cycle got ctrl=%b A=%b B=%b exp 000 00 00", {ifs, ids, exf}, fa, fb);
    end
    tick();
    checks++;
    if ({fa, fb} !== 4'b0101 || scnt !== 16'd1) begin
      failures++; $display("FAIL load_use_wb_fwd got A=%b B=%b scnt=%0d exp A=01 B=01 scnt=1", fa, fb, scnt);
    end
  endtask

  // addi x0,x1,1 ; add x6,x0,x0 and lw x0 ; use x0
  task automatic test_x0();
    do_reset();
    drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd0, 0, 0); tick();
    drive(1, 1, 5'd0, 1, 5'd0, 1, 5'd6, 0, 0); tick();
    checks++;
    if ({fa, fb} !== 4'b0000) begin failures++; $display("FAIL x0_sel got A=%b B=%b exp 00 00", fa, fb); end
    drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd0, 1, 0); tick();
    drive(1, 1, 5'd0, 1, 5'd0, 1, 5'd6, 0, 0);
    checks++;
    if (ifs !== 1'b0) begin failures++; $display("FAIL x0_load_nostall got=%b exp=0", ifs); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0); tick();
    drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 1);
    checks++;
    if ({ifs, ids, idf, exf, memf} !== 5'b00111) begin
      failures++; $display("FAIL redirect_ctrl got=%b exp=00111", {ifs, ids, idf, exf, memf});
    end
    tick();
    checks++;
    if (fcnt !== 16'd1 || scnt !== 16'd0 || fa !== 2'b00) begin
      failures++; $display("FAIL redirect_cnt got fcnt=%0d scnt=%0d A=%b exp 1 0 00", fcnt, scnt, fa);
    end
    br = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0); tick();
      drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0); tick();
    end
    checks++;
    if (scnt2 !== 2'd3 || scnt !== 16'd5) begin
      failures++; $display("FAIL stall_saturate got narrow=%0d wide=%0d exp 3 5", scnt2, scnt);
    end
    drive(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0); tick();
    drive(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 0, 0);
    checks++;
    if (ifs !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got=%b exp=1", ifs); end
    rst = 1'b1;
    #1;
    checks++;
    if ({fa, fb, ifs, ids, idf, exf, memf, scnt, fcnt, ifs2, exf2, scnt2} !== '0) begin
      failures++; $display("FAIL async_reset got ctrl=%b scnt=%0d scnt2=%0d exp zero", {ifs, ids, idf, exf, memf}, scnt, scnt2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (ifs !== 1'b0) begin failures++; $display("FAIL scoreboard_cleared got stall=%b exp=0", ifs); end
    tick();
    checks++;
    if ({fa, fb} !== 4'b0000) begin failures++; $display("FAIL scoreboard_cleared_sel got A=%b B=%b exp 00 00", fa, fb); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)),
            $urandom_range(1, 0) == 1, 5'($urandom_range(3, 0)),
            $urandom_range(3, 0) != 0, 5'($urandom_range(3, 0)),
            $urandom_range(2, 0) == 0, $urandom_range(9, 0) == 0);
      checks++;
      if ({ifs, ids, idf, exf, memf} !== m_ctrl() || {ifs2, ids2, idf2, exf2, memf2} !== m_ctrl()) begin
        failures++; $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i, {ifs, ids, idf, exf, memf}, m_ctrl());
      end
      tick();
      checks++;
      if (fa !== e_fa || fb !== e_fb || fa2 !== e_fa || fb2 !== e_fb) begin
        failures++; $display("FAIL rand_sel[%0d] got A=%b B=%b exp A=%b B=%b", i, fa, fb, e_fa, e_fb);
      end
      checks++;
      if (scnt !== 16'(e_scnt) || fcnt !== 16'(e_fcnt) || scnt2 !== 2'(e_scnt2) || fcnt2 !== 2'(e_fcnt2)) begin
        failures++; $display("FAIL rand_cnt[%0d] got s=%0d f=%0d s2=%0d f2=%0d exp %0d %0d %0d %0d",
                             i, scnt, fcnt, scnt2, fcnt2, e_scnt, e_fcnt, e_scnt2, e_fcnt2);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_x0();
    test_redirect();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
